rv64g_l1_array_ctrl: RTL and testbench
======================================

Name: rv64g_l1_array_ctrl

Overview:
- Sequencer and arbiter in front of the L1 data/tag/state arrays (one access port, 8-word lines).
- Shares the port among four requesters: core stores, line refill, dirty-line writeback reads, and cache flush.
- Multi-beat fills and writebacks run through a word counter, so the arrays only ever see one legal single-word access per cycle.

Parameters:
SETS, 32, number of sets
WAYS, 8, associativity (way select is 3 bits)
TAG_W, 53, tag width
INDEX_W, 5, set index width

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
st_valid_i / st_ready_o  in/out  1  core store handshake
st_index_i, st_word_i, st_way_i, st_be_i  in  INDEX_W,3,3,8  store target and byte enables
st_wdata_i, st_tag_i, st_state_i  in  64,TAG_W,2  store data, tag and state to write
fill_req_i / fill_gnt_o  in/out  1  refill request; grant is a 1-cycle pulse
fill_index_i, fill_way_i, fill_tag_i, fill_state_i  in  INDEX_W,3,TAG_W,2  refill target (sampled at grant)
fill_valid_i / fill_ready_o, fill_data_i  in/out, in  1,64  refill beat handshake
fill_done_o  out  1  pulse after the 8th beat
wb_req_i / wb_gnt_o, wb_index_i, wb_way_i  in/out, in  1,INDEX_W,3  writeback request and target (sampled at grant)
wb_valid_o / wb_ready_i  out/in  1  writeback beat handshake
wb_data_o, wb_tag_o, wb_last_o  out  64,TAG_W,1  writeback beat data, line tag, last-beat flag
flush_req_i / flush_done_o  in/out  1  invalidate-all request and completion pulse
arr_index_o, arr_word_o, arr_way_o  out  INDEX_W,3,3  array address
arr_we_o, arr_be_o, arr_wdata_o, arr_tag_o, arr_state_o  out  1,8,64,TAG_W,2  array write controls
arr_inval_all_o  out  1  array invalidate-all strobe
arr_rdata_i, arr_tag_i  in  64,TAG_W  array selected-way read data and tag (combinational read)

Behaviour:
- FSM states: IDLE, FILL, WB, FLUSH.
- Reset (rst_ni low at posedge) from any state:
  - forces IDLE and clears the word counter and latched request fields;
  - drives all outputs to 0, with arr_state_o = MESI_N.
  - A fill or writeback in flight is abandoned silently; requesters must re-request.
- IDLE priority: flush > wb > fill > store.
  - Flush request: go to FLUSH.
  - Writeback request: pulse wb_gnt_o, latch index/way, counter = 0, go to WB.
  - Fill request: pulse fill_gnt_o, latch index/way/tag/state, counter = 0, go to FILL.
  - Otherwise st_ready_o = 1 combinationally in IDLE.
- Store (st_valid_i && st_ready_o):
  - same-cycle array write: arr_we_o = 1, store fields passed through, 0-cycle latency.
  - st_ready_o is 0 whenever a higher-priority request is present or the FSM is not in IDLE.
- FILL:
  - fill_ready_o = 1.
  - Each cycle with fill_valid_i: write word = counter, be = 8'hFF, data = fill_data_i, tag = latched tag.
  - arr_state_o = MESI_N for beats 0..6; the latched fill state only on beat 7, so a partial line is never valid.
  - The counter increments per accepted beat and stalls when fill_valid_i = 0.
  - After beat 7: pulse fill_done_o in the same cycle, go to IDLE.
- WB:
  - arr_we_o = 0; address = latched index/way, word = counter.
  - wb_valid_o = 1, wb_data_o = arr_rdata_i, wb_tag_o = arr_tag_i, wb_last_o = (counter == 7).
  - A beat advances only on wb_ready_i.
  - Data must stay stable while wb_valid_o && !wb_ready_i.
  - After the last handshake: go to IDLE. Line state is not changed.
- FLUSH: assert arr_inval_all_o and flush_done_o for exactly one cycle, then go to IDLE.
- Counter is 3 bits; it wraps from 7 to 0 only on FSM exit, never inside a transaction.
- Requests arriving during FILL/WB/FLUSH wait for IDLE. There is no preemption.
- Minimum gap between back-to-back transactions is one IDLE cycle.

Decomposition:
- Shared params.vh adds:
  - FSM state encodings (L1C_IDLE/FILL/WB/FLUSH);
  - WORDS_PER_LINE;
  - the existing MESI_* codes, reused here.
- One sub-module: rv64g_l1_req_arb, a fixed-priority 4-input arbiter that outputs a one-hot grant valid only in IDLE.
- Beat counter and datapath muxing stay inline.

Test Plan:
- Store in IDLE: st_index=3, word=5, way=2, be=8'h0F, data=64'hAABB_CCDD_1122_3344 -> same cycle arr_we_o=1 with those fields passed through; st_ready_o=1.
- Fill: index=7, way=4, state=MESI_E, 8 beats of data k*0x11 with fill_valid_i dropped for 2 cycles at beat 3 ->
  - writes to words 0..7 in order;
  - arr_state_o=N on beats 0..6 and E on beat 7;
  - fill_done_o single pulse; back in IDLE next cycle.
- Writeback: way=1, index=9, wb_ready_i toggled 1/0 -> 8 beats on words 0..7, data stable while stalled, wb_last_o only on beat 7, arr_we_o never asserted.
- Simultaneous flush_req, wb_req, fill_req and st_valid in IDLE ->
  - FLUSH first (arr_inval_all_o for 1 cycle);
  - then WB, then FILL;
  - the store is accepted only after FILL completes.
- rst_ni low for 1 cycle at FILL beat 4 -> IDLE next cycle, all outputs 0, no fill_done_o; a re-issued fill restarts at word 0.

Source files
------------

// File: rtl/rv64g_l1_array_ctrl_pkg.sv
// Shared constants and types for the L1 array sequencer: FSM encodings,
// MESI line-state codes and requester indices used by the arbiter.
package rv64g_l1_array_ctrl_pkg;

    localparam int SETS           = 32;
    localparam int WAYS           = 8;
    localparam int WORDS_PER_LINE = 8;

    typedef enum logic [1:0] {
        L1C_IDLE  = 2'd0,
        L1C_FILL  = 2'd1,
        L1C_WB    = 2'd2,
        L1C_FLUSH = 2'd3
    } l1c_state_e;

    localparam logic [1:0] MESI_N = 2'b00;
    localparam logic [1:0] MESI_S = 2'b01;
    localparam logic [1:0] MESI_E = 2'b10;
    localparam logic [1:0] MESI_M = 2'b11;

    // Requester slots, lowest index = lowest priority.
    localparam int REQ_ST    = 0;
    localparam int REQ_FILL  = 1;
    localparam int REQ_WB    = 2;
    localparam int REQ_FLUSH = 3;

    function automatic logic is_last_word(input logic [2:0] word);
        return word == 3'(WORDS_PER_LINE - 1);
    endfunction

endpackage

// File: rtl/rv64g_l1_req_arb.sv
// Fixed-priority arbiter for the array port: flush > writeback > fill > store.
// Grants are one-hot and only ever asserted while the sequencer is idle.
module rv64g_l1_req_arb
    import rv64g_l1_array_ctrl_pkg::*;
(
    input  logic       idle,
    input  logic [3:0] req,
    output logic [3:0] gnt
);

    // NOTE: gnt gets a default before any branch so no path through this
    // block leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        gnt = '0;
        if (idle) begin
            if (req[REQ_FLUSH])     gnt[REQ_FLUSH] = 1'b1;
            else if (req[REQ_WB])   gnt[REQ_WB]    = 1'b1;
            else if (req[REQ_FILL]) gnt[REQ_FILL]  = 1'b1;
            else if (req[REQ_ST])   gnt[REQ_ST]    = 1'b1;
        end
    end

endmodule

// File: rtl/rv64g_l1_array_ctrl.sv
// L1 data/tag/state array sequencer: arbitrates stores, refills, writebacks and
// flush onto the single array port, stepping multi-beat transfers one word per cycle.
module rv64g_l1_array_ctrl
    import rv64g_l1_array_ctrl_pkg::*;
#(
    parameter int TAG_W   = 53,
    parameter int INDEX_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_ni,

    input  logic               st_valid_i,
    output logic               st_ready_o,
    input  logic [INDEX_W-1:0] st_index_i,
    input  logic [2:0]         st_word_i,
    input  logic [2:0]         st_way_i,
    input  logic [7:0]         st_be_i,
    input  logic [63:0]        st_wdata_i,
    input  logic [TAG_W-1:0]   st_tag_i,
    input  logic [1:0]         st_state_i,

    input  logic               fill_req_i,
    output logic               fill_gnt_o,
    input  logic [INDEX_W-1:0] fill_index_i,
    input  logic [2:0]         fill_way_i,
    input  logic [TAG_W-1:0]   fill_tag_i,
    input  logic [1:0]         fill_state_i,
    input  logic               fill_valid_i,
    output logic               fill_ready_o,
    input  logic [63:0]        fill_data_i,
    output logic               fill_done_o,

    input  logic               wb_req_i,
    output logic               wb_gnt_o,
    input  logic [INDEX_W-1:0] wb_index_i,
    input  logic [2:0]         wb_way_i,
    output logic               wb_valid_o,
    input  logic               wb_ready_i,
    output logic [63:0]        wb_data_o,
    output logic [TAG_W-1:0]   wb_tag_o,
    output logic               wb_last_o,

    input  logic               flush_req_i,
    output logic               flush_done_o,

    output logic [INDEX_W-1:0] arr_index_o,
    output logic [2:0]         arr_word_o,
    output logic [2:0]         arr_way_o,
    output logic               arr_we_o,
    output logic [7:0]         arr_be_o,
    output logic [63:0]        arr_wdata_o,
    output logic [TAG_W-1:0]   arr_tag_o,
    output logic [1:0]         arr_state_o,
    output logic               arr_inval_all_o,
    input  logic [63:0]        arr_rdata_i,
    input  logic [TAG_W-1:0]   arr_tag_i
);

    l1c_state_e         state_q;
    logic [2:0]         cnt_q;
    logic [INDEX_W-1:0] idx_q;
    logic [2:0]         way_q;
    logic [TAG_W-1:0]   tag_q;
    logic [1:0]         fstate_q;

    logic               idle;
    logic [3:0]         req;
    logic [3:0]         gnt;
    logic               st_fire;
    logic               last_word;

    assign idle      = rst_ni && (state_q == L1C_IDLE);
    assign last_word = is_last_word(cnt_q);

    // The store slot is always "requesting" so its grant doubles as st_ready.
    always_comb begin
        req            = '0;
        req[REQ_FLUSH] = flush_req_i;
        req[REQ_WB]    = wb_req_i;
        req[REQ_FILL]  = fill_req_i;
        req[REQ_ST]    = 1'b1;
    end

    rv64g_l1_req_arb u_arb (
        .idle (idle),
        .req  (req),
        .gnt  (gnt)
    );

    assign st_fire = gnt[REQ_ST] && st_valid_i;

    // Outputs are decoded from the registered state; all held at zero during reset.
    always_comb begin
        st_ready_o      = 1'b0;
        fill_gnt_o      = 1'b0;
        fill_ready_o    = 1'b0;
        fill_done_o     = 1'b0;
        wb_gnt_o        = 1'b0;
        wb_valid_o      = 1'b0;
        wb_data_o       = '0;
        wb_tag_o        = '0;
        wb_last_o       = 1'b0;
        flush_done_o    = 1'b0;
        arr_index_o     = '0;
        arr_word_o      = '0;
        arr_way_o       = '0;
        arr_we_o        = 1'b0;
        arr_be_o        = '0;
        arr_wdata_o     = '0;
        arr_tag_o       = '0;
        arr_state_o     = MESI_N;
        arr_inval_all_o = 1'b0;
        if (rst_ni) begin
            case (state_q)
                L1C_IDLE: begin
                    st_ready_o = gnt[REQ_ST];
                    fill_gnt_o = gnt[REQ_FILL];
                    wb_gnt_o   = gnt[REQ_WB];
                    if (st_fire) begin
                        arr_we_o    = 1'b1;
                        arr_index_o = st_index_i;
                        arr_word_o  = st_word_i;
                        arr_way_o   = st_way_i;
                        arr_be_o    = st_be_i;
                        arr_wdata_o = st_wdata_i;
                        arr_tag_o   = st_tag_i;
                        arr_state_o = st_state_i;
                    end
                end
                L1C_FILL: begin
                    fill_ready_o = 1'b1;
                    arr_we_o     = fill_valid_i;
                    arr_index_o  = idx_q;
                    arr_word_o   = cnt_q;
                    arr_way_o    = way_q;
                    arr_be_o     = 8'hFF;
                    arr_wdata_o  = fill_data_i;
                    arr_tag_o    = tag_q;
                    // A partially refilled line stays invalid until its last word lands.
                    arr_state_o  = last_word ? fstate_q : MESI_N;
                    fill_done_o  = fill_valid_i && last_word;
                end
                L1C_WB: begin
                    wb_valid_o  = 1'b1;
                    arr_index_o = idx_q;
                    arr_word_o  = cnt_q;
                    arr_way_o   = way_q;
                    wb_data_o   = arr_rdata_i;
                    wb_tag_o    = arr_tag_i;
                    wb_last_o   = last_word;
                end
                L1C_FLUSH: begin
                    arr_inval_all_o = 1'b1;
                    flush_done_o    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= L1C_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            way_q    <= '0;
            tag_q    <= '0;
            fstate_q <= MESI_N;
        end else begin
            case (state_q)
                L1C_IDLE: begin
                    if (gnt[REQ_FLUSH]) begin
                        state_q <= L1C_FLUSH;
                    end else if (gnt[REQ_WB]) begin
                        state_q <= L1C_WB;
                        idx_q   <= wb_index_i;
                        way_q   <= wb_way_i;
                        cnt_q   <= '0;
                    end else if (gnt[REQ_FILL]) begin
                        state_q  <= L1C_FILL;
                        idx_q    <= fill_index_i;
                        way_q    <= fill_way_i;
                        tag_q    <= fill_tag_i;
                        fstate_q <= fill_state_i;
                        cnt_q    <= '0;
                    end
                end
                L1C_FILL: begin
                    if (fill_valid_i) begin
                        cnt_q <= cnt_q + 3'd1;
                        if (last_word) state_q <= L1C_IDLE;
                    end
                end
                L1C_WB: begin
                    if (wb_ready_i) begin
                        cnt_q <= cnt_q + 3'd1;
                        if (last_word) state_q <= L1C_IDLE;
                    end
                end
                L1C_FLUSH: state_q <= L1C_IDLE;
                default:   state_q <= L1C_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv64g_l1_array_ctrl.sv
// Self-checking bench: emulates the L1 arrays, runs directed scenarios and random
// traffic, and compares every output against a transaction-level model each cycle.
module tb_rv64g_l1_array_ctrl;
    import rv64g_l1_array_ctrl_pkg::*;

    localparam int TW = 53;
    localparam int IW = 5;
    localparam int M_IDLE = 0, M_FILL = 1, M_WB = 2, M_FLUSH = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_ni;
    logic           st_valid, st_ready_o;
    logic [IW-1:0]  st_index;
    logic [2:0]     st_word, st_way;
    logic [7:0]     st_be;
    logic [63:0]    st_wdata;
    logic [TW-1:0]  st_tag;
    logic [1:0]     st_state;
    logic           fill_req, fill_gnt_o;
    logic [IW-1:0]  fill_index;
    logic [2:0]     fill_way;
    logic [TW-1:0]  fill_tag;
    logic [1:0]     fill_state;
    logic           fill_valid, fill_ready_o, fill_done_o;
    logic [63:0]    fill_data;
    logic           wb_req, wb_gnt_o;
    logic [IW-1:0]  wb_index;
    logic [2:0]     wb_way;
    logic           wb_valid_o, wb_ready, wb_last_o;
    logic [63:0]    wb_data_o;
    logic [TW-1:0]  wb_tag_o;
    logic           flush_req, flush_done_o;
    logic [IW-1:0]  arr_index_o;
    logic [2:0]     arr_word_o, arr_way_o;
    logic           arr_we_o, arr_inval_all_o;
    logic [7:0]     arr_be_o;
    logic [63:0]    arr_wdata_o, arr_rdata_i;
    logic [TW-1:0]  arr_tag_o, arr_tag_i;
    logic [1:0]     arr_state_o;

    rv64g_l1_array_ctrl #(.TAG_W(TW), .INDEX_W(IW)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .st_valid_i(st_valid), .st_ready_o(st_ready_o), .st_index_i(st_index),
        .st_word_i(st_word), .st_way_i(st_way), .st_be_i(st_be), .st_wdata_i(st_wdata),
        .st_tag_i(st_tag), .st_state_i(st_state),
        .fill_req_i(fill_req), .fill_gnt_o(fill_gnt_o), .fill_index_i(fill_index),
        .fill_way_i(fill_way), .fill_tag_i(fill_tag), .fill_state_i(fill_state),
        .fill_valid_i(fill_valid), .fill_ready_o(fill_ready_o), .fill_data_i(fill_data),
        .fill_done_o(fill_done_o),
        .wb_req_i(wb_req), .wb_gnt_o(wb_gnt_o), .wb_index_i(wb_index), .wb_way_i(wb_way),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready), .wb_data_o(wb_data_o),
        .wb_tag_o(wb_tag_o), .wb_last_o(wb_last_o),
        .flush_req_i(flush_req), .flush_done_o(flush_done_o),
        .arr_index_o(arr_index_o), .arr_word_o(arr_word_o), .arr_way_o(arr_way_o),
        .arr_we_o(arr_we_o), .arr_be_o(arr_be_o), .arr_wdata_o(arr_wdata_o),
        .arr_tag_o(arr_tag_o), .arr_state_o(arr_state_o), .arr_inval_all_o(arr_inval_all_o),
        .arr_rdata_i(arr_rdata_i), .arr_tag_i(arr_tag_i)
    );

    // Array emulation, addressed by whatever the DUT drives.
    logic [63:0]   emu_data [0:2047];
    logic [TW-1:0] emu_tag  [0:255];
    assign arr_rdata_i = emu_data[{arr_index_o, arr_way_o, arr_word_o}];
    assign arr_tag_i   = emu_tag[{arr_index_o, arr_way_o}];

    always @(posedge clk) begin
        if (arr_we_o) begin
            emu_data[{arr_index_o, arr_way_o, arr_word_o}] <=
                merge(emu_data[{arr_index_o, arr_way_o, arr_word_o}], arr_wdata_o, arr_be_o);
            emu_tag[{arr_index_o, arr_way_o}] <= arr_tag_o;
        end
    end

    // Reference model: expected line contents plus the current transaction.
    logic [63:0]   model_data [0:2047];
    logic [TW-1:0] model_tag  [0:255];
    int            mop, mbeat, midx, mway;
    logic [TW-1:0] mtag;
    logic [1:0]    mst;

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                          input logic [7:0] be);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic int daddr(input int i, input int w, input int k);
        return (i * 8 + w) * 8 + k;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_write(input int i, input int w, input int k, input logic [7:0] be,
                               input logic [63:0] d, input logic [TW-1:0] t);
        model_data[daddr(i, w, k)] = merge(model_data[daddr(i, w, k)], d, be);
        model_tag[i * 8 + w] = t;
    endtask

    // Compare every DUT output against the model at the falling edge.
    task automatic probe();
        logic e_st_ready, e_fill_gnt, e_fill_ready, e_fill_done, e_wb_gnt, e_wb_valid;
        logic e_wb_last, e_flush_done, e_we, e_inval, hi;
        logic [IW-1:0] e_idx;
        logic [2:0] e_word, e_way;
        logic [7:0] e_be;
        logic [63:0] e_wdata, e_wb_data;
        logic [TW-1:0] e_tag, e_wb_tag;
        logic [1:0] e_state;
        @(negedge clk);
        {e_st_ready, e_fill_gnt, e_fill_ready, e_fill_done, e_wb_gnt, e_wb_valid} = '0;
        {e_wb_last, e_flush_done, e_we, e_inval} = '0;
        e_idx = '0; e_word = '0; e_way = '0; e_be = '0; e_wdata = '0; e_wb_data = '0;
        e_tag = '0; e_wb_tag = '0; e_state = MESI_N;
        hi = flush_req || wb_req || fill_req;
        if (rst_ni) begin
            case (mop)
                M_IDLE: begin
                    e_st_ready = !hi;
                    e_wb_gnt   = !flush_req && wb_req;
                    e_fill_gnt = !flush_req && !wb_req && fill_req;
                    if (st_valid && !hi) begin
                        e_we = 1'b1; e_idx = st_index; e_word = st_word; e_way = st_way;
                        e_be = st_be; e_wdata = st_wdata; e_tag = st_tag; e_state = st_state;
                    end
                end
                M_FILL: begin
                    e_fill_ready = 1'b1;
                    e_we = fill_valid;
                    e_idx = IW'(midx); e_way = 3'(mway); e_word = 3'(mbeat);
                    e_be = 8'hFF; e_wdata = fill_data; e_tag = mtag;
                    e_state = (mbeat == 7) ? mst : MESI_N;
                    e_fill_done = fill_valid && (mbeat == 7);
                end
                M_WB: begin
                    e_wb_valid = 1'b1;
                    e_idx = IW'(midx); e_way = 3'(mway); e_word = 3'(mbeat);
                    e_wb_data = model_data[daddr(midx, mway, mbeat)];
                    e_wb_tag  = model_tag[midx * 8 + mway];
                    e_wb_last = (mbeat == 7);
                end
                default: begin
                    e_inval = 1'b1;
                    e_flush_done = 1'b1;
                end
            endcase
        end
        check("st_ready", st_ready_o, e_st_ready);
        check("fill_gnt", fill_gnt_o, e_fill_gnt);
        check("fill_ready", fill_ready_o, e_fill_ready);
        check("fill_done", fill_done_o, e_fill_done);
        check("wb_gnt", wb_gnt_o, e_wb_gnt);
        check("wb_valid", wb_valid_o, e_wb_valid);
        check("wb_last", wb_last_o, e_wb_last);
        check("flush_done", flush_done_o, e_flush_done);
        check("arr_inval_all", arr_inval_all_o, e_inval);
        check("arr_we", arr_we_o, e_we);
        if (e_we || e_wb_valid) begin
            check("arr_index", arr_index_o, e_idx);
            check("arr_word", arr_word_o, e_word);
            check("arr_way", arr_way_o, e_way);
        end
        if (e_we) begin
            check("arr_be", arr_be_o, e_be);
            check("arr_wdata", arr_wdata_o, e_wdata);
            check("arr_tag", arr_tag_o, e_tag);
            check("arr_state", arr_state_o, e_state);
        end
        if (e_wb_valid) begin
            check("wb_data", wb_data_o, e_wb_data);
            check("wb_tag", wb_tag_o, e_wb_tag);
        end
        if (!rst_ni) check("rst_arr_state", arr_state_o, MESI_N);
    endtask

    // Advance the model on the rising edge, then release inputs for the next cycle.
    task automatic tick();
        @(posedge clk);
        if (!rst_ni) begin
            mop = M_IDLE; mbeat = 0;
        end else begin
            case (mop)
                M_IDLE: begin
                    if (flush_req) mop = M_FLUSH;
                    else if (wb_req) begin
                        mop = M_WB; midx = int'(wb_index); mway = int'(wb_way); mbeat = 0;
                    end else if (fill_req) begin
                        mop = M_FILL; midx = int'(fill_index); mway = int'(fill_way);
                        mtag = fill_tag; mst = fill_state; mbeat = 0;
                    end else if (st_valid)
                        model_write(int'(st_index), int'(st_way), int'(st_word), st_be, st_wdata, st_tag);
                end
                M_FILL: if (fill_valid) begin
                    model_write(midx, mway, mbeat, 8'hFF, fill_data, mtag);
                    if (mbeat == 7) begin mop = M_IDLE; mbeat = 0; end
                    else mbeat++;
                end
                M_WB: if (wb_ready) begin
                    if (mbeat == 7) begin mop = M_IDLE; mbeat = 0; end
                    else mbeat++;
                end
                default: mop = M_IDLE;
            endcase
        end
        #1;
    endtask

    task automatic quiet_inputs();
        st_valid = 0; st_index = '0; st_word = '0; st_way = '0; st_be = '0; st_wdata = '0;
        st_tag = '0; st_state = MESI_N;
        fill_req = 0; fill_index = '0; fill_way = '0; fill_tag = '0; fill_state = MESI_N;
        fill_valid = 0; fill_data = '0;
        wb_req = 0; wb_index = '0; wb_way = '0; wb_ready = 0; flush_req = 0;
    endtask

    initial begin
        int k, stall, beats, order, invals;
        logic prev_stall, saw_inval, saw_wb, saw_fill, st_done;
        logic [63:0] prev_data, r;

        for (int i = 0; i < 2048; i++) begin
            r = {$urandom, $urandom};
            emu_data[i] = r; model_data[i] = r;
        end
        for (int i = 0; i < 256; i++) begin
            r = {$urandom, $urandom};
            emu_tag[i] = r[TW-1:0]; model_tag[i] = r[TW-1:0];
        end
        for (int i = 0; i < 8; i++) begin
            emu_data[daddr(9, 1, i)]   = 64'hC0DE_0000_0000_0000 + 64'(i);
            model_data[daddr(9, 1, i)] = 64'hC0DE_0000_0000_0000 + 64'(i);
        end
        mop = M_IDLE; mbeat = 0; midx = 0; mway = 0; mtag = '0; mst = MESI_N;

        // Reset: everything low while held.
        quiet_inputs(); rst_ni = 0; st_valid = 1; fill_req = 1;
        probe(); check("rst_st_ready", st_ready_o, 0); check("rst_fill_gnt", fill_gnt_o, 0);
        tick(); quiet_inputs();
        probe(); tick();
        rst_ni = 1;
        probe(); check("idle_st_ready", st_ready_o, 1);
        tick();

        // Store in IDLE: zero-latency pass-through.
        st_valid = 1; st_index = 5'd3; st_word = 3'd5; st_way = 3'd2; st_be = 8'h0F;
        st_wdata = 64'hAABB_CCDD_1122_3344; st_tag = 53'h1_2345_6789; st_state = MESI_M;
        probe();
        check("st_we", arr_we_o, 1); check("st_index", arr_index_o, 3);
        check("st_word", arr_word_o, 5); check("st_way", arr_way_o, 2);
        check("st_be", arr_be_o, 8'h0F); check("st_wdata", arr_wdata_o, 64'hAABB_CCDD_1122_3344);
        tick(); st_valid = 0;

        // Fill with a two-cycle stall before beat 3.
        fill_req = 1; fill_index = 5'd7; fill_way = 3'd4; fill_tag = 53'h1234_5678_9ABC;
        fill_state = MESI_E;
        probe(); check("fill_gnt_pulse", fill_gnt_o, 1);
        tick(); fill_req = 0;
        k = 0; stall = 0;
        for (int c = 0; c < 20 && k < 8; c++) begin
            if (k == 3 && stall < 2) begin fill_valid = 0; stall++; end
            else begin fill_valid = 1; fill_data = 64'(k) * 64'h11; end
            probe();
            if (fill_valid) begin
                check("fill_word", arr_word_o, 64'(k));
                check("fill_wdata", arr_wdata_o, 64'(k) * 64'h11);
                check("fill_state", arr_state_o, (k == 7) ? MESI_E : MESI_N);
                check("fill_done_beat", fill_done_o, (k == 7) ? 1 : 0);
            end else check("fill_stall_we", arr_we_o, 0);
            tick();
            if (fill_valid) k++;
        end
        check("fill_beats", 64'(k), 64'd8);
        fill_valid = 0;
        probe(); check("fill_after_done", fill_done_o, 0); check("fill_back_idle", st_ready_o, 1);
        tick();

        // Writeback with ready toggling.
        wb_req = 1; wb_index = 5'd9; wb_way = 3'd1;
        probe(); check("wb_gnt_pulse", wb_gnt_o, 1);
        tick(); wb_req = 0;
        beats = 0; prev_stall = 0; prev_data = '0;
        for (int c = 0; c < 40 && beats < 8; c++) begin
            wb_ready = (c % 2 == 0);
            probe();
            check("wb_no_we", arr_we_o, 0);
            check("wb_word", arr_word_o, 64'(beats));
            check("wb_beat_data", wb_data_o, 64'hC0DE_0000_0000_0000 + 64'(beats));
            check("wb_last_only7", wb_last_o, (beats == 7) ? 1 : 0);
            if (prev_stall) check("wb_stable", wb_data_o, prev_data);
            prev_stall = wb_valid_o && !wb_ready;
            prev_data = wb_data_o;
            if (wb_valid_o && wb_ready) beats++;
            tick();
        end
        check("wb_beats", 64'(beats), 64'd8);
        wb_ready = 0;

        // All four requesters at once: flush, then wb, then fill, then the store.
        flush_req = 1; wb_req = 1; wb_index = 5'd2; wb_way = 3'd6;
        fill_req = 1; fill_index = 5'd5; fill_way = 3'd3; fill_tag = 53'h0BAD_F00D; fill_state = MESI_S;
        st_valid = 1; st_index = 5'd1; st_word = 3'd0; st_way = 3'd7; st_be = 8'hF0;
        st_wdata = 64'h0123_4567_89AB_CDEF; st_tag = 53'h77; st_state = MESI_M;
        fill_valid = 1; wb_ready = 1;
        order = 0; invals = 0; st_done = 0;
        for (int c = 0; c < 60 && !st_done; c++) begin
            fill_data = {$urandom, $urandom};
            probe();
            saw_inval = arr_inval_all_o; saw_wb = wb_gnt_o; saw_fill = fill_gnt_o;
            if (saw_inval) begin order = order * 16 + 1; invals++; end
            if (saw_wb) order = order * 16 + 2;
            if (saw_fill) order = order * 16 + 3;
            if (st_valid && st_ready_o) begin order = order * 16 + 4; st_done = 1; end
            tick();
            if (saw_inval) flush_req = 0;
            if (saw_wb) wb_req = 0;
            if (saw_fill) fill_req = 0;
            if (st_done) st_valid = 0;
        end
        check("prio_order", 64'(order), 64'h1234);
        check("flush_one_cycle", 64'(invals), 64'd1);
        quiet_inputs();

        // Reset in the middle of a fill, then re-issue it.
        fill_req = 1; fill_index = 5'd12; fill_way = 3'd0; fill_tag = 53'h3; fill_state = MESI_E;
        probe(); tick(); fill_req = 0; fill_valid = 1;
        for (int i = 0; i < 4; i++) begin
            fill_data = {$urandom, $urandom};
            probe(); tick();
        end
        rst_ni = 0;
        probe();
        check("rst_fill_done", fill_done_o, 0); check("rst_we", arr_we_o, 0);
        check("rst_fill_ready", fill_ready_o, 0);
        tick(); rst_ni = 1; fill_valid = 0;
        probe(); check("post_rst_fill_ready", fill_ready_o, 0); check("post_rst_idle", st_ready_o, 1);
        tick();
        fill_req = 1;
        probe(); check("refill_gnt", fill_gnt_o, 1);
        tick(); fill_req = 0; fill_valid = 1;
        for (int i = 0; i < 8; i++) begin
            fill_data = {$urandom, $urandom};
            probe();
            check("refill_word", arr_word_o, 64'(i));
            tick();
        end
        quiet_inputs();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst_ni     = ($urandom_range(0, 299) != 0);
            flush_req  = ($urandom_range(0, 39) == 0);
            wb_req     = ($urandom_range(0, 9) == 0);
            fill_req   = ($urandom_range(0, 9) == 0);
            st_valid   = ($urandom_range(0, 1) == 0);
            st_index   = IW'($urandom); st_word = 3'($urandom); st_way = 3'($urandom);
            st_be      = 8'($urandom); st_wdata = {$urandom, $urandom};
            r          = {$urandom, $urandom};
            st_tag     = r[TW-1:0]; st_state = 2'($urandom);
            fill_index = IW'($urandom); fill_way = 3'($urandom);
            r          = {$urandom, $urandom};
            fill_tag   = r[TW-1:0]; fill_state = 2'($urandom);
            fill_valid = ($urandom_range(0, 9) < 7);
            fill_data  = {$urandom, $urandom};
            wb_index   = IW'($urandom); wb_way = 3'($urandom);
            wb_ready   = ($urandom_range(0, 9) < 6);
            probe(); tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
